// File: rtl/pack.sv
// Packet serializer: buffers one packet of input words, then shifts it out MSB-first, one bit per request.
// Build option PACK_PREAMBLE_EN: the first SIZE_PREAMBLE bits of each packet come from PREAMBLE.
module pack #(
  parameter int SIZE_BIT_PACK   = 1976,
  parameter int SIZE_INPUT_BIT  = 8,
  parameter int SIZE_OUTPUT_BIT = 1,
  parameter int SIZE_PREAMBLE   = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'hCF80AA31
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  output logic                       o_ready,
  input  logic [SIZE_INPUT_BIT-1:0]  i_data,
  input  logic                       i_ready_output,
  input  logic                       i_valid_input,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid
);
  localparam int NBYTES = SIZE_BIT_PACK / SIZE_INPUT_BIT;
  localparam int AW     = $clog2(NBYTES);
  localparam int RW     = $clog2(SIZE_BIT_PACK);
  localparam int BW     = $clog2(SIZE_INPUT_BIT);
`ifdef PACK_PREAMBLE_EN
  localparam int WR_FIRST = SIZE_PREAMBLE / SIZE_INPUT_BIT;
`else
  localparam int WR_FIRST = 0;
`endif

  typedef enum logic {WRITE, READ} state_t;
  state_t state;

  logic [SIZE_INPUT_BIT-1:0] mem [NBYTES];
  logic [AW-1:0]             wr_addr;
  logic [RW-1:0]             rd_idx;
  logic [AW-1:0]             rd_byte;
  logic [BW-1:0]             rd_bit;
  logic [SIZE_INPUT_BIT-1:0] cur_byte;
  logic                      cur_bit;
  logic                      wr_en, rd_en;

  assign wr_en   = (state == WRITE) && i_valid_input;
  assign rd_en   = (state == READ) && i_ready_output;
  assign rd_byte = AW'(rd_idx / RW'(SIZE_INPUT_BIT));
  assign rd_bit  = BW'(rd_idx % RW'(SIZE_INPUT_BIT));

`ifdef PACK_PREAMBLE_EN
  // Preamble bytes live in constant logic rather than the RAM, so reset can never disturb them.
  logic [SIZE_PREAMBLE-1:0] pre_shift;
  assign pre_shift = PREAMBLE << (int'(rd_byte) * SIZE_INPUT_BIT);
  assign cur_byte  = (int'(rd_byte) < WR_FIRST) ? pre_shift[SIZE_PREAMBLE-1 -: SIZE_INPUT_BIT]
                                                : mem[rd_byte];
`else
  assign cur_byte  = mem[rd_byte];
`endif

  assign cur_bit = cur_byte[BW'(SIZE_INPUT_BIT-1) - rd_bit];

  always_ff @(posedge i_clk)
    if (wr_en && !i_reset) mem[wr_addr] <= i_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= WRITE;
      wr_addr <= AW'(WR_FIRST);
      rd_idx  <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= rd_en;
      if (wr_en) begin
        if (wr_addr == AW'(NBYTES-1)) begin
          state   <= READ;
          wr_addr <= AW'(WR_FIRST);
          o_ready <= 1'b0;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (rd_en) begin
        o_data <= SIZE_OUTPUT_BIT'(cur_bit);
        if (rd_idx == RW'(SIZE_BIT_PACK-1)) begin
          state   <= WRITE;
          rd_idx  <= '0;
          o_ready <= 1'b1;
        end else begin
          rd_idx  <= rd_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pack.sv
// Directed bench for pack: packet write/read, handshake noise, mid-write and mid-read reset.
module tb_pack;
  localparam int NB   = 247;
  localparam int NBIT = 1976;
`ifdef PACK_PREAMBLE_EN
  localparam int NPRE = 4;
`else
  localparam int NPRE = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset, o_ready, i_ready_output, i_valid_input, o_valid;
  logic [7:0] i_data;
  logic [0:0] o_data;

  always #5 i_clk = ~i_clk;

  pack dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_ready(o_ready), .i_data(i_data),
    .i_ready_output(i_ready_output), .i_valid_input(i_valid_input),
    .o_data(o_data), .o_valid(o_valid)
  );

  int         checks = 0, failures = 0;
  logic [7:0] pkt [NB];
  logic       got [NBIT];

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gbyte(input int b);
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++) v = {v[6:0], got[b*8+j]};
    return v;
  endfunction

  function automatic logic [31:0] gword0();
    logic [31:0] v = '0;
    for (int j = 0; j < 32; j++) v = {v[30:0], got[j]};
    return v;
  endfunction

  // mode: 0 scrambled, 1 incrementing from 0, 2 constant A5, 3 descending
  task automatic write_pkt(input int mode, input int cnt, input int gap, input int req_last);
    int vbad = 0, rbad = 0;
    logic [7:0] v;
    for (int i = NPRE; i < NPRE + cnt; i++) begin
      case (mode)
        0:       v = 8'(i*37 + 11);
        1:       v = 8'(i - NPRE);
        2:       v = 8'hA5;
        default: v = 8'(255 - i);
      endcase
      pkt[i] = v;
      i_data = v; i_valid_input = 1'b1;
      i_ready_output = (req_last != 0) && (i == NB-1);
      tick;
      i_valid_input = 1'b0; i_ready_output = 1'b0;
      if (o_valid !== 1'b0) vbad++;
      if (i != NB-1 && o_ready !== 1'b1) rbad++;
      if (gap != 0 && i != NB-1) begin
        i_ready_output = 1'b1;
        tick;
        i_ready_output = 1'b0;
        if (o_valid !== 1'b0) vbad++;
      end
    end
    chk("wr_no_valid", vbad, 0);
    chk("wr_ready_held", rbad, 0);
    if (NPRE + cnt == NB) chk("wr_done_ready_low", {31'b0, o_ready}, 0);
  endtask

  task automatic read_pkt(input int held, input int noise, input int n);
    int vbad = 0, hbad = 0, rbad = 0, nbad = 0;
    for (int k = 0; k < n; k++) begin
      i_ready_output = 1'b1;
      tick;
      if (o_valid !== 1'b1) vbad++;
      if (k < NBIT-1 && o_ready !== 1'b0) rbad++;
      got[k] = o_data[0];
      if (held == 0) begin
        i_ready_output = 1'b0;
        i_valid_input  = (noise != 0) && (k < NBIT-1);
        i_data         = 8'hFF;
        tick;
        i_valid_input  = 1'b0;
        if (o_valid !== 1'b0) vbad++;
        if (o_data[0] !== got[k]) hbad++;
      end
    end
    i_ready_output = 1'b0;
    if (n == NBIT) begin
      chk("rd_valid_pattern", vbad, 0);
      chk("rd_hold_data", hbad, 0);
      chk("rd_ready_low", rbad, 0);
      chk("rd_done_ready", {31'b0, o_ready}, 1);
      for (int k = 0; k < NBIT; k++)
        if (got[k] !== pkt[k/8][7 - k%8]) nbad++;
      chk("stream_bits", nbad, 0);
      tick;
      chk("rd_idle_valid", {31'b0, o_valid}, 0);
    end
  endtask

  initial begin
    logic [31:0] pre_w;
    pre_w = 32'hCF80AA31;
    for (int i = 0; i < 4; i++) pkt[i] = pre_w[31-8*i -: 8];
    i_reset = 1'b1; i_data = '0; i_ready_output = 1'b0; i_valid_input = 1'b0;
    tick; tick;
    chk("rst_ready", {31'b0, o_ready}, 1);
    chk("rst_valid", {31'b0, o_valid}, 0);
    chk("rst_data",  {31'b0, o_data},  0);
    i_reset = 1'b0;

    // Gapped writes with stray requests, pulsed reads with stray writes.
    write_pkt(0, NB-NPRE, 1, 1);
    read_pkt(0, 1, NBIT);
`ifdef PACK_PREAMBLE_EN
    chk("preamble", gword0(), 32'hCF80AA31);
`else
    chk("first_word", gword0(), {8'd11, 8'd48, 8'd85, 8'd122});
`endif

    // Back-to-back writes and held read request.
    write_pkt(1, NB-NPRE, 0, 0);
    read_pkt(1, 0, NBIT);
`ifdef PACK_PREAMBLE_EN
    chk("bits32_39", {24'b0, gbyte(4)}, 32'h00);
    chk("bits_last", {24'b0, gbyte(NB-1)}, 32'hF2);
`else
    chk("bits32_39", {24'b0, gbyte(4)}, 32'h04);
    chk("bits_last", {24'b0, gbyte(NB-1)}, 32'hF6);
`endif

    // Reset after 100 bytes written, then a full packet.
    write_pkt(3, 100, 0, 0);
    i_reset = 1'b1; tick; i_reset = 1'b0;
    chk("midwr_rst_ready", {31'b0, o_ready}, 1);
    chk("midwr_rst_valid", {31'b0, o_valid}, 0);
    write_pkt(3, NB-NPRE, 0, 0);
    read_pkt(0, 0, NBIT);

    // Reset partway through a read, then a full A5 packet.
    write_pkt(2, NB-NPRE, 0, 0);
    read_pkt(1, 0, 500);
    i_reset = 1'b1; tick; i_reset = 1'b0;
    chk("midrd_rst_ready", {31'b0, o_ready}, 1);
    chk("midrd_rst_valid", {31'b0, o_valid}, 0);
    chk("midrd_rst_data",  {31'b0, o_data},  0);
    write_pkt(2, NB-NPRE, 0, 0);
    read_pkt(1, 0, NBIT);
    chk("a5_last_byte", {24'b0, gbyte(NB-1)}, 32'hA5);
`ifdef PACK_PREAMBLE_EN
    chk("a5_preamble", gword0(), 32'hCF80AA31);
`else
    chk("a5_first_word", gword0(), 32'hA5A5A5A5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
